// File: rtl/axi_sram_slave.sv
// AXI3 slave over a 2^MEM_AW x 32 register array; every burst is INCR with 4-byte beats.
// Optional AXI_SLAVE_RAND_DELAY_EN inserts LFSR-driven stalls on the ready/valid outputs.
module axi_sram_slave #(
    parameter int MEM_AW = 10
) (
    input  logic        aclk,
    input  logic        areset,
    input  logic [3:0]  arid,
    input  logic [31:0] araddr,
    input  logic [7:0]  arlen,
    input  logic [2:0]  arsize,
    input  logic [1:0]  arburst,
    input  logic [1:0]  arlock,
    input  logic [3:0]  arcache,
    input  logic [2:0]  arprot,
    input  logic        arvalid,
    output logic        arready,
    output logic [3:0]  rid,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rlast,
    output logic        rvalid,
    input  logic        rready,
    input  logic [3:0]  awid,
    input  logic [31:0] awaddr,
    input  logic [7:0]  awlen,
    input  logic [2:0]  awsize,
    input  logic [1:0]  awburst,
    input  logic [1:0]  awlock,
    input  logic [3:0]  awcache,
    input  logic [2:0]  awprot,
    input  logic        awvalid,
    output logic        awready,
    input  logic [3:0]  wid,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wlast,
    input  logic        wvalid,
    output logic        wready,
    output logic [3:0]  bid,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready,
    output logic        r_state_dbg,
    output logic [1:0]  w_state_dbg
);

    // Handshake rule on every channel: a transfer happens on the rising edge where
    // valid and ready are both 1; once this slave raises rvalid/bvalid it holds it until then.

    typedef enum logic {R_IDLE = 1'b0, R_DATA = 1'b1} r_state_t;
    typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} w_state_t;

    localparam int DEPTH = 1 << MEM_AW;

    logic [31:0] mem [DEPTH];

    logic g_ar, g_aw, g_w, g_rv, g_b;

`ifdef AXI_SLAVE_RAND_DELAY_EN
    logic [15:0] lfsr;
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) lfsr <= 16'hACE1;
        else        lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end
    assign g_ar = lfsr[0];
    assign g_aw = lfsr[1];
    assign g_w  = lfsr[2];
    assign g_rv = lfsr[3];
    assign g_b  = lfsr[4];
    logic unused_lfsr;
    assign unused_lfsr = ^lfsr[15:5];
`else
    assign g_ar = 1'b1;
    assign g_aw = 1'b1;
    assign g_w  = 1'b1;
    assign g_rv = 1'b1;
    assign g_b  = 1'b1;
`endif

    logic unused_inputs;
    assign unused_inputs = ^{arsize, arburst, arlock, arcache, arprot, araddr[31:MEM_AW+2], araddr[1:0],
                             awsize, awburst, awlock, awcache, awprot, awaddr[31:MEM_AW+2], awaddr[1:0],
                             wid, wlast};

    // ---------------- read channel ----------------
    r_state_t          r_state, r_next;
    logic [3:0]        r_id;
    logic [MEM_AW-1:0] r_addr;
    logic [7:0]        r_len, r_cnt;
    logic              r_shown;
    logic              ar_fire, r_fire;

    always_comb begin
        r_next  = r_state;
        arready = 1'b0;
        rvalid  = 1'b0;
        case (r_state)
            R_IDLE: begin
                arready = !areset && g_ar;
                if (arvalid && arready) r_next = R_DATA;
            end
            R_DATA: begin
                rvalid = r_shown || g_rv;
                if (rvalid && rready && (r_cnt == r_len)) r_next = R_IDLE;
            end
            default: r_next = R_IDLE;
        endcase
    end

    assign ar_fire     = arvalid && arready;
    assign r_fire      = rvalid && rready;
    assign rlast       = rvalid && (r_cnt == r_len);
    assign rdata       = (r_state == R_DATA) ? mem[r_addr] : 32'h0;
    assign rid         = r_id;
    assign rresp       = 2'b00;
    assign r_state_dbg = r_state;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_state <= R_IDLE;
            r_id    <= '0;
            r_addr  <= '0;
            r_len   <= '0;
            r_cnt   <= '0;
            r_shown <= 1'b0;
        end else begin
            r_state <= r_next;
            if (ar_fire) begin
                r_id    <= arid;
                r_addr  <= araddr[MEM_AW+1:2];
                r_len   <= arlen;
                r_cnt   <= '0;
                r_shown <= 1'b0;
            end else if (r_fire) begin
                r_addr  <= r_addr + 1'b1;
                r_cnt   <= r_cnt + 8'd1;
                r_shown <= 1'b0;
            end else if (rvalid) begin
                r_shown <= 1'b1;
            end
        end
    end

    // ---------------- write channel ----------------
    w_state_t          w_state, w_next;
    logic [3:0]        w_id;
    logic [MEM_AW-1:0] w_addr;
    logic [7:0]        w_len, w_cnt;
    logic              b_shown;
    logic              aw_fire, w_fire, b_fire;

    always_comb begin
        w_next  = w_state;
        awready = 1'b0;
        wready  = 1'b0;
        bvalid  = 1'b0;
        case (w_state)
            W_IDLE: begin
                awready = !areset && g_aw;
                if (awvalid && awready) w_next = W_DATA;
            end
            W_DATA: begin
                wready = g_w;
                if (wvalid && wready && (w_cnt == w_len)) w_next = W_RESP;
            end
            W_RESP: begin
                bvalid = b_shown || g_b;
                if (bvalid && bready) w_next = W_IDLE;
            end
            default: w_next = W_IDLE;
        endcase
    end

    assign aw_fire     = awvalid && awready;
    assign w_fire      = wvalid && wready;
    assign b_fire      = bvalid && bready;
    assign bid         = w_id;
    assign bresp       = 2'b00;
    assign w_state_dbg = w_state;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            w_state <= W_IDLE;
            w_id    <= '0;
            w_addr  <= '0;
            w_len   <= '0;
            w_cnt   <= '0;
            b_shown <= 1'b0;
        end else begin
            w_state <= w_next;
            if (aw_fire) begin
                w_id    <= awid;
                w_addr  <= awaddr[MEM_AW+1:2];
                w_len   <= awlen;
                w_cnt   <= '0;
                b_shown <= 1'b0;
            end else if (w_fire) begin
                w_addr  <= w_addr + 1'b1;
                w_cnt   <= w_cnt + 8'd1;
            end else if (b_fire) begin
                b_shown <= 1'b0;
            end else if (bvalid) begin
                b_shown <= 1'b1;
            end
        end
    end

    // Memory is not reset; wready is forced low by the async reset, so no write can slip in.
    always_ff @(posedge aclk) begin
        if (w_fire) begin
            for (int n = 0; n < 4; n++) begin
                if (wstrb[n]) mem[w_addr][8*n +: 8] <= wdata[8*n +: 8];
            end
        end
    end

endmodule

// File: tb/tb_axi_sram_slave.sv
// Directed bench for axi_sram_slave: inputs driven and outputs checked on the falling edge,
// read expectations queued in exp_q and popped per beat.
module tb_axi_sram_slave;

    logic        aclk = 1'b0;
    logic        areset;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst, arlock;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic        arvalid, arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast, rvalid, rready;
    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst, awlock;
    logic [3:0]  awcache;
    logic [2:0]  awprot;
    logic        awvalid, awready;
    logic [3:0]  wid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast, wvalid, wready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid, bready;
    logic        r_state_dbg;
    logic [1:0]  w_state_dbg;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_q[$];
    logic [31:0] wbuf [16];
    logic [3:0]  sbuf [16];

    axi_sram_slave #(.MEM_AW(10)) dut (
        .aclk(aclk), .areset(areset),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .r_state_dbg(r_state_dbg), .w_state_dbg(w_state_dbg)
    );

    // ---------------- clock / watchdog ----------------
    always #5 aclk = ~aclk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- checker ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp_v);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic wr_burst(input logic [3:0] id, input logic [31:0] addr, input int len);
        int n;
        awid = id; awaddr = addr; awlen = 8'(len); awvalid = 1'b1;
        n = 0;
        while (!awready && n < 50) begin @(negedge aclk); n++; end
        chk("aw_ready", 32'(awready), 32'd1);
        @(negedge aclk);
        awvalid = 1'b0;
        for (int i = 0; i <= len; i++) begin
            wdata = wbuf[i]; wstrb = sbuf[i]; wlast = (i == len); wvalid = 1'b1;
            n = 0;
            while (!wready && n < 50) begin @(negedge aclk); n++; end
            chk("w_ready", 32'(wready), 32'd1);
            @(negedge aclk);
        end
        wvalid = 1'b0; wlast = 1'b0; bready = 1'b1;
        n = 0;
        while (!bvalid && n < 50) begin @(negedge aclk); n++; end
        chk("b_valid", 32'(bvalid), 32'd1);
        chk("bid", 32'(bid), 32'(id));
        chk("bresp", 32'(bresp), 32'd0);
        @(negedge aclk);
        bready = 1'b0;
        chk("aw_idle", 32'(awready), 32'd1);
    endtask

    task automatic rd_burst(input logic [3:0] id, input logic [31:0] addr, input int len, input int stall);
        int n;
        logic [31:0] e;
        arid = id; araddr = addr; arlen = 8'(len); arvalid = 1'b1;
        n = 0;
        while (!arready && n < 50) begin @(negedge aclk); n++; end
        chk("ar_ready", 32'(arready), 32'd1);
        chk("rvalid_pre", 32'(rvalid), 32'd0);
        @(negedge aclk);
        arvalid = 1'b0;
        chk("rvalid_lat", 32'(rvalid), 32'd1);
        for (int s = 0; s < stall; s++) begin
            chk("bp_rvalid", 32'(rvalid), 32'd1);
            chk("bp_rdata", rdata, exp_q[0]);
            chk("bp_rid", 32'(rid), 32'(id));
            @(negedge aclk);
        end
        for (int i = 0; i <= len; i++) begin
            rready = 1'b1;
            n = 0;
            while (!rvalid && n < 50) begin @(negedge aclk); n++; end
            chk("r_valid", 32'(rvalid), 32'd1);
            e = exp_q.pop_front();
            chk("rdata", rdata, e);
            chk("rlast", 32'(rlast), 32'(i == len));
            chk("rid", 32'(rid), 32'(id));
            chk("rresp", 32'(rresp), 32'd0);
            @(negedge aclk);
        end
        rready = 1'b0;
        chk("ar_idle", 32'(arready), 32'd1);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        areset = 1'b1;
        arid = '0; araddr = '0; arlen = '0; arsize = 3'd2; arburst = 2'd1;
        arlock = '0; arcache = '0; arprot = '0; arvalid = 1'b0; rready = 1'b0;
        awid = '0; awaddr = '0; awlen = '0; awsize = 3'd2; awburst = 2'd1;
        awlock = '0; awcache = '0; awprot = '0; awvalid = 1'b0;
        wid = '0; wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;

        // reset state
        repeat (3) @(negedge aclk);
        chk("rst_arready", 32'(arready), 32'd0);
        chk("rst_awready", 32'(awready), 32'd0);
        chk("rst_wready",  32'(wready),  32'd0);
        chk("rst_rvalid",  32'(rvalid),  32'd0);
        chk("rst_rlast",   32'(rlast),   32'd0);
        chk("rst_bvalid",  32'(bvalid),  32'd0);
        chk("rst_rid",     32'(rid),     32'd0);
        chk("rst_bid",     32'(bid),     32'd0);
        chk("rst_rdata",   rdata,        32'd0);
        areset = 1'b0;
        #1;
        chk("post_rst_arready", 32'(arready), 32'd1);
        chk("post_rst_awready", 32'(awready), 32'd1);
        chk("post_rst_rstate",  32'(r_state_dbg), 32'd0);
        @(negedge aclk);

        // single write + readback
        wbuf[0] = 32'hDEADBEEF; sbuf[0] = 4'hF;
        wr_burst(4'd1, 32'h10, 0);
        exp_q.push_back(32'hDEADBEEF);
        rd_burst(4'd2, 32'h10, 0, 0);

        // partial strobe: lanes 0 and 2 only
        wbuf[0] = 32'h11223344; sbuf[0] = 4'b0101;
        wr_burst(4'd3, 32'h10, 0);
        exp_q.push_back(32'hDE22BE44);
        rd_burst(4'd4, 32'h10, 0, 0);

        // 4-beat burst
        for (int i = 0; i < 4; i++) begin wbuf[i] = 32'(i); sbuf[i] = 4'hF; end
        wr_burst(4'd5, 32'h100, 3);
        for (int i = 0; i < 4; i++) exp_q.push_back(32'(i));
        rd_burst(4'd6, 32'h100, 3, 0);

        // backpressure: 5 cycles of rready=0 before the first beat
        for (int i = 0; i < 4; i++) exp_q.push_back(32'(i));
        rd_burst(4'd7, 32'h100, 3, 5);

        // wrap from word 1023 to word 0
        wbuf[0] = 32'hA1A1A1A1; wbuf[1] = 32'hB2B2B2B2; sbuf[0] = 4'hF; sbuf[1] = 4'hF;
        wr_burst(4'd8, 32'hFFC, 1);
        exp_q.push_back(32'hA1A1A1A1); exp_q.push_back(32'hB2B2B2B2);
        rd_burst(4'd9, 32'hFFC, 1, 0);
        exp_q.push_back(32'hB2B2B2B2);
        rd_burst(4'd10, 32'h1000, 0, 0);

        // reset in W_DATA with a beat presented: word 0 must keep its value
        awid = 4'd11; awaddr = 32'h0; awlen = 8'd3; awvalid = 1'b1;
        chk("mr_awready", 32'(awready), 32'd1);
        @(negedge aclk);
        awvalid = 1'b0;
        chk("mr_wstate", 32'(w_state_dbg), 32'd1);
        wdata = 32'hCAFEF00D; wstrb = 4'hF; wvalid = 1'b1;
        areset = 1'b1;
        #1;
        chk("mr_wready",  32'(wready),  32'd0);
        chk("mr_awready0", 32'(awready), 32'd0);
        chk("mr_arready0", 32'(arready), 32'd0);
        chk("mr_bvalid",  32'(bvalid),  32'd0);
        chk("mr_rvalid",  32'(rvalid),  32'd0);
        chk("mr_bid",     32'(bid),     32'd0);
        chk("mr_wstate0", 32'(w_state_dbg), 32'd0);
        repeat (2) @(negedge aclk);
        wvalid = 1'b0;
        areset = 1'b0;
        #1;
        chk("mr_awready1", 32'(awready), 32'd1);
        @(negedge aclk);
        exp_q.push_back(32'hB2B2B2B2);
        rd_burst(4'd12, 32'h0, 0, 0);

        // concurrent read and write of the same word
        wbuf[0] = 32'h11111111; sbuf[0] = 4'hF;
        wr_burst(4'd13, 32'h200, 0);
        arid = 4'd1; araddr = 32'h200; arlen = 8'd0; arvalid = 1'b1;
        awid = 4'd2; awaddr = 32'h200; awlen = 8'd0; awvalid = 1'b1;
        chk("cc_arready", 32'(arready), 32'd1);
        chk("cc_awready", 32'(awready), 32'd1);
        @(negedge aclk);
        arvalid = 1'b0; awvalid = 1'b0;
        wdata = 32'h22222222; wstrb = 4'hF; wlast = 1'b1; wvalid = 1'b1; rready = 1'b1;
        #1;
        chk("cc_rvalid", 32'(rvalid), 32'd1);
        chk("cc_wready", 32'(wready), 32'd1);
        chk("cc_old_rdata", rdata, 32'h11111111);
        chk("cc_rlast", 32'(rlast), 32'd1);
        @(negedge aclk);
        wvalid = 1'b0; wlast = 1'b0; rready = 1'b0;
        chk("cc_r_done", 32'(arready), 32'd1);
        chk("cc_rvalid_off", 32'(rvalid), 32'd0);
        chk("cc_bvalid", 32'(bvalid), 32'd1);
        chk("cc_bid", 32'(bid), 32'd2);
        bready = 1'b1;
        @(negedge aclk);
        bready = 1'b0;
        chk("cc_w_done", 32'(awready), 32'd1);
        exp_q.push_back(32'h22222222);
        rd_burst(4'd3, 32'h200, 0, 0);

        chk("exp_q_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
